// File: rtl/clock_divider_bank.sv
// clock_divider_bank: bank of independent runtime-programmable square-wave dividers
// with glitch-free terminal-count updates and a bank-wide phase-aligning restart.
module clock_divider_bank #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 32,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_LIMIT = {32'd12499999, 32'd249999, 32'd24999999, 32'd49999999},
    parameter int CH_W = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] tick_rise,
    output logic [NUM_CH-1:0] pending
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] limit_act;
        logic [CNT_W-1:0] limit_pend;
        logic pend;
        logic co;
        logic tk;
        logic tr;
        logic wr_hit;
        logic term;
        logic apply;
        assign wr_hit = wr_en && wr_ch == CH_W'(i);
        assign term = cnt == limit_act;
        // Limit changes only take effect at half-period boundaries or while stopped.
        assign apply = sync_restart || !en[i] || term;
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                limit_act <= DEF_LIMIT[i*CNT_W +: CNT_W];
                limit_pend <= DEF_LIMIT[i*CNT_W +: CNT_W];
                pend <= 1'b0;
                co <= 1'b0;
                tk <= 1'b0;
                tr <= 1'b0;
            end else begin
                limit_pend <= wr_hit ? wr_data : limit_pend;
                limit_act <= apply ? (wr_hit ? wr_data : limit_pend) : limit_act;
                pend <= !apply && (wr_hit || pend);
                if (sync_restart || !en[i]) begin
                    cnt <= '0;
                    co <= 1'b0;
                    tk <= 1'b0;
                    tr <= 1'b0;
                end else if (term) begin
                    cnt <= '0;
                    co <= !co;
                    tk <= 1'b1;
                    tr <= !co;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    tk <= 1'b0;
                    tr <= 1'b0;
                end
            end
        end
        assign clk_out[i] = co;
        assign tick[i] = tk;
        assign tick_rise[i] = tr;
        assign pending[i] = pend;
    end
endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed checks of divider timing, limit updates,
// enable/disable, bank restart, address decode and asynchronous reset.
module tb_clock_divider_bank;
    localparam logic [31:0] DEF = {8'd5, 8'd0, 8'd1, 8'd3};

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = 4'h0;
    logic       sync_restart = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_ch = 4'h0;
    logic [7:0] wr_data = 8'h0;
    logic [3:0] clk_out;
    logic [3:0] tick;
    logic [3:0] tick_rise;
    logic [3:0] pending;
    int vectors = 0;
    int miscompares = 0;

    clock_divider_bank #(.NUM_CH(4), .CNT_W(8), .DEF_LIMIT(DEF), .CH_W(4)) dut (
        .clk_in(clk_in), .rst(rst), .en(en), .sync_restart(sync_restart),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .clk_out(clk_out), .tick(tick), .tick_rise(tick_rise), .pending(pending)
    );

    always #5 clk_in = ~clk_in;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic write(input logic [3:0] ch, input logic [7:0] data);
        wr_en = 1'b1;
        wr_ch = ch;
        wr_data = data;
    endtask

    task automatic do_reset(input logic [3:0] en_val);
        rst = 1'b1;
        sync_restart = 1'b0;
        wr_en = 1'b0;
        en = en_val;
        step(2);
        rst = 1'b0;
    endtask

    // Free-running expectation j edges after counting starts from cnt=0:
    // a channel with limit L toggles on every edge where j is a multiple of L+1.
    function automatic logic [11:0] run_exp(input int j, input int l0, input int l1, input int l2, input int l3);
        int lim[4];
        logic [3:0] c;
        logic [3:0] t;
        lim = '{l0, l1, l2, l3};
        for (int i = 0; i < 4; i++) begin
            c[i] = ((j / (lim[i] + 1)) % 2) == 1;
            t[i] = (j % (lim[i] + 1)) == 0;
        end
        return {c, t, c & t};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        en = 4'hF;
        step(2);
        vectors++;
        if ({clk_out, tick, tick_rise, pending} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0000", {clk_out, tick, tick_rise, pending});
        end
        step(3);
        vectors++;
        if ({clk_out, tick, tick_rise, pending} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_hold got %h want 0000", {clk_out, tick, tick_rise, pending});
        end
        rst = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            vectors++;
            if ({clk_out, tick, tick_rise} !== run_exp(k, 3, 1, 0, 5)) begin
                miscompares++;
                $display("FAIL default_run k=%0d got %b want %b", k, {clk_out, tick, tick_rise}, run_exp(k, 3, 1, 0, 5));
            end
        end
    endtask

    task automatic test_pending_apply();
        logic [3:0] exp;
        do_reset(4'hF);
        step();
        write(0, 8'd7);
        for (int k = 2; k <= 20; k++) begin
            step();
            if (k == 2) wr_en = 1'b0;
            exp = {(k >= 4 && k < 12) || k >= 20, k == 4 || k == 12 || k == 20, k == 4 || k == 20, k == 2 || k == 3};
            vectors++;
            if ({clk_out[0], tick[0], tick_rise[0], pending[0]} !== exp) begin
                miscompares++;
                $display("FAIL pending_apply k=%0d got %b want %b", k, {clk_out[0], tick[0], tick_rise[0], pending[0]}, exp);
            end
        end
    endtask

    task automatic test_write_at_terminal();
        logic [3:0] exp;
        do_reset(4'hF);
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) write(0, 8'd5);
            if (k == 2) write(0, 8'd2);
            if (k == 3 || k == 7) wr_en = 1'b0;
            if (k == 6) write(0, 8'd1);
            exp = {(k >= 4 && k < 7) || (k >= 9 && k < 11) || k >= 13, k inside {4, 7, 9, 11, 13}, k inside {4, 9, 13}, k inside {2, 3}};
            vectors++;
            if ({clk_out[0], tick[0], tick_rise[0], pending[0]} !== exp) begin
                miscompares++;
                $display("FAIL write_at_terminal k=%0d got %b want %b", k, {clk_out[0], tick[0], tick_rise[0], pending[0]}, exp);
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] exp;
        do_reset(4'hF);
        step(3);
        en = 4'b1101;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3) write(1, 8'd4);
            if (k == 4) wr_en = 1'b0;
            vectors++;
            if ({clk_out[1], tick[1], tick_rise[1]} !== 3'b000) begin
                miscompares++;
                $display("FAIL disabled_quiet k=%0d got %b want 000", k, {clk_out[1], tick[1], tick_rise[1]});
            end
            if (k == 6) begin
                vectors++;
                if (pending[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL disabled_write_pending got %b want 0", pending[1]);
                end
            end
        end
        en = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = {k >= 5 && k < 10, k == 5 || k == 10, k == 5, 1'b0};
            vectors++;
            if ({clk_out[1], tick[1], tick_rise[1], pending[1]} !== exp) begin
                miscompares++;
                $display("FAIL reenable k=%0d got %b want %b", k, {clk_out[1], tick[1], tick_rise[1], pending[1]}, exp);
            end
        end
    endtask

    task automatic test_max_limit();
        logic [1:0] exp;
        do_reset(4'b1101);
        step();
        write(1, 8'd255);
        step();
        wr_en = 1'b0;
        step();
        en = 4'hF;
        for (int k = 1; k <= 512; k++) begin
            step();
            exp = {k >= 256 && k < 512, k == 256 || k == 512};
            vectors++;
            if ({clk_out[1], tick[1]} !== exp) begin
                miscompares++;
                $display("FAIL max_limit k=%0d got %b want %b", k, {clk_out[1], tick[1]}, exp);
            end
        end
    endtask

    task automatic test_sync_restart();
        do_reset(4'hF);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 7) begin
                vectors++;
                if (pending[3] !== 1'b1) begin
                    miscompares++;
                    $display("FAIL sync_pre_pending got %b want 1", pending[3]);
                end
            end
            if (k == 8) begin
                vectors++;
                if ({clk_out, tick, tick_rise, pending} !== 16'h0) begin
                    miscompares++;
                    $display("FAIL sync_clear got %h want 0000", {clk_out, tick, tick_rise, pending});
                end
            end
            if (k > 8) begin
                vectors++;
                if ({clk_out, tick, tick_rise} !== run_exp(k - 8, 3, 1, 3, 3)) begin
                    miscompares++;
                    $display("FAIL sync_aligned k=%0d got %b want %b", k, {clk_out, tick, tick_rise}, run_exp(k - 8, 3, 1, 3, 3));
                end
            end
            if (k == 1) write(2, 8'd3);
            if (k == 2) wr_en = 1'b0;
            if (k == 6) write(3, 8'd3);
            if (k == 7) begin
                wr_en = 1'b0;
                sync_restart = 1'b1;
            end
            if (k == 8) sync_restart = 1'b0;
        end
    endtask

    task automatic test_bad_channel_and_reset();
        do_reset(4'hF);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) write(5, 8'd0);
            if (k == 2) wr_en = 1'b0;
            vectors++;
            if ({clk_out, tick, tick_rise, pending} !== {run_exp(k, 3, 1, 0, 5), 4'h0}) begin
                miscompares++;
                $display("FAIL bad_channel k=%0d got %b want %b", k, {clk_out, tick, tick_rise, pending}, {run_exp(k, 3, 1, 0, 5), 4'h0});
            end
        end
        write(0, 8'd7);
        step();
        wr_en = 1'b0;
        vectors++;
        if (pending !== 4'b0001) begin
            miscompares++;
            $display("FAIL pre_reset_pending got %b want 0001", pending);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({clk_out, tick, tick_rise, pending} !== 16'h0) begin
            miscompares++;
            $display("FAIL async_reset got %h want 0000", {clk_out, tick, tick_rise, pending});
        end
        step(2);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            vectors++;
            if ({clk_out, tick, tick_rise, pending} !== {run_exp(k, 3, 1, 0, 5), 4'h0}) begin
                miscompares++;
                $display("FAIL post_reset k=%0d got %b want %b", k, {clk_out, tick, tick_rise, pending}, {run_exp(k, 3, 1, 0, 5), 4'h0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_pending_apply();
        test_write_at_terminal();
        test_disable();
        test_max_limit();
        test_sync_restart();
        test_bad_channel_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
Parametrised bank of NUM_CH independent square-wave clock dividers driven from clk_in. Each channel has a half-period terminal count that can be changed at runtime, a per-channel enable, and a one-cycle toggle strobe. A bank-wide synchronous restart phase-aligns all channels. The bank supplies slow timing domains (1 Hz, 2 Hz, display scan, blink) to the rest of the design and replaces fixed per-rate counter blocks.

Parameters:
NUM_CH, 4, number of divider channels (1..16)
CNT_W, 32, counter and terminal-count width in bits
DEF_LIMIT, {32'd12499999, 32'd249999, 32'd24999999, 32'd49999999}, packed NUM_CH*CNT_W reset terminal counts; channel i uses bits [i*CNT_W +: CNT_W]. Defaults give ch0 1 Hz, ch1 2 Hz, ch2 200 Hz, ch3 4 Hz from 100 MHz.
CH_W, 4, width of the channel select field (must satisfy 2^CH_W >= NUM_CH)

Ports:
clk_in  input  1  system clock
rst  input  1  reset, asynchronous, active-high
en  input  NUM_CH  per-channel run enable, level
sync_restart  input  1  one-cycle pulse; restarts all channels in phase
wr_en  input  1  terminal-count write strobe
wr_ch  input  CH_W  channel addressed by the write
wr_data  input  CNT_W  new terminal count
clk_out  output  NUM_CH  divided clock level per channel (registered)
tick  output  NUM_CH  one-cycle strobe on every clk_out toggle
tick_rise  output  NUM_CH  one-cycle strobe on a 0->1 clk_out toggle only
pending  output  NUM_CH  new terminal count written but not yet applied

Behaviour:
- Per-channel state: cnt[CNT_W], limit_act[CNT_W], limit_pend[CNT_W], pend flag, clk_out, tick, tick_rise. All outputs are registered.
- Reset (async): cnt=0, limit_act=limit_pend=DEF_LIMIT slice, pend=0, clk_out=0, tick=0, tick_rise=0. rst asserted mid-operation aborts everything, including pending writes.
- Running (en[i]=1): if cnt==limit_act, then cnt<=0, clk_out toggles, tick<=1, and tick_rise<=1 iff clk_out was 0. Otherwise cnt<=cnt+1 and tick=tick_rise=0.
- Timing: the toggle occurs every limit_act+1 cycles; the output period is 2*(limit_act+1) cycles. limit_act=0 toggles every cycle (clk_in/2). tick rises in the same cycle as the clk_out edge.
- Wrap: cnt never exceeds limit_act. limit_act = 2^CNT_W-1 is legal, and cnt wraps to 0 at terminal.
- Write (wr_en=1, wr_ch<NUM_CH): channel wr_ch captures limit_pend<=wr_data and pend<=1. wr_ch>=NUM_CH is ignored with no state change.
- Apply rule (glitch-free): the pending value is loaded into limit_act only at a terminal event (cnt==limit_act), at sync_restart, or immediately when en[i]=0. pend then clears. A running half-period is never shortened or lengthened mid-way.
- Write in the same cycle as that channel's terminal event: wr_data loads directly into limit_act at that boundary and pend stays 0.
- Second write before apply: it overwrites limit_pend; only the last value is applied.
- Disabled (en[i]=0): cnt<=0, clk_out<=0, tick=tick_rise=0. Writes apply the cycle after the write. On re-enable, the first toggle (0->1, with tick and tick_rise) occurs limit_act+1 cycles after en rises.
- sync_restart=1: has priority over terminal and count for all channels. cnt<=0, clk_out<=0, tick=tick_rise=0, and pending values apply. Enabled channels then produce their first rising toggle limit_act+1 cycles later, all in phase.
- Priority per channel: rst > sync_restart > en=0 > terminal > count.
- There is no combinational path from inputs to outputs.

Test Plan:
1. Reset defaults with override NUM_CH=4, CNT_W=8, DEF_LIMIT={5,0,1,3}, en=4'hF -> ch0 toggles every 4 cycles (period 8), ch1 every 2, ch2 every cycle, ch3 every 6. tick pulses 1 cycle at each toggle; tick_rise pulses on alternate toggles only.
2. ch0 running with limit 3 at cnt=1: write wr_ch=0, wr_data=7 -> pending[0]=1. The current half-period still ends after 4 cycles total, then the next half-periods are 8 cycles and pending[0] clears at that boundary.
3. Write coinciding with ch0 terminal (wr_data=1) -> the next half-period is 2 cycles and pending[0] never asserts. A second write before apply (5 then 2) -> 2 is applied.
4. en[1]=0 for 10 cycles -> clk_out[1]=0 and tick[1]=0 throughout. A write of 4 applies next cycle. After en[1]=1, the first rising toggle occurs at exactly 5 cycles.
5. sync_restart pulse with channels at random phases -> all clk_out=0 next cycle. Channels with equal limits then toggle in the same cycle, with tick_rise aligned. A sync_restart in the same cycle as a terminal event suppresses that toggle.
6. wr_ch=5 with NUM_CH=4 -> no state change. rst asserted mid-half-period with pending set -> immediate clear, limits return to DEF_LIMIT, pending=0, and counting resumes from 0 after rst falls.
